// File: rtl/regfile_pkg.sv
// Package for the parametrised register file.
// Holds the default geometry of the register file and the address of the
// hard-wired zero register, shared by the top level and the scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  // Register hard-wired to zero when ZERO_REG is enabled.
  localparam int ZERO_ADDR  = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard for the register file.
// One pending bit per register. ID sets a bit when it issues an instruction
// that will write that register; WB clears it when the result is written;
// a pipeline flush clears every bit.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   issue_en_i        ID issues an instruction writing issue_addr_i
//   issue_addr_i      destination of the issuing instruction
//   wr_en_i           WB write strobe
//   wr_addr_i         WB destination register
//   flush_i           pipeline redirect, clears all pending bits
//   rd_addr_i         packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   busy_raw_o        pending bit of each port's register (no bypass masking)
//   issue_conflict_o  registered pulse: last issue hit an already-pending reg
//   busy_count_o      registered popcount of the pending bits
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_en_i,
  input  logic [ADDR_W-1:0]        issue_addr_i,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic                     flush_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD-1:0]        busy_raw_o,
  output logic                     issue_conflict_o,
  output logic [ADDR_W:0]          busy_count_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] pend_q, pend_d;
  logic             conflict_q, conflict_d;
  logic [ADDR_W:0]  count_q, count_d;
  logic             issue_ok;
  logic             wr_same;

  always_comb begin
    // Issues during a flush, or to the zero register, have no effect at all.
    issue_ok = issue_en_i && !flush_i &&
               !(ZERO_REG && (issue_addr_i == ADDR_W'(ZERO_ADDR)));
    wr_same  = wr_en_i && (wr_addr_i == issue_addr_i);

    // Priority: flush > issue set > write clear > hold. Applying the write
    // clear before the issue set lets the issue win on the same register.
    pend_d = pend_q;
    if (flush_i) begin
      pend_d = '0;
    end else begin
      if (wr_en_i)  pend_d[wr_addr_i]    = 1'b0;
      if (issue_ok) pend_d[issue_addr_i] = 1'b1;
    end

    // WAW: re-issuing a register whose earlier result is not being written now.
    conflict_d = issue_ok && pend_q[issue_addr_i] && !wr_same;

    // Count is taken from the next state so it is registered in the same
    // edge as the bits it describes.
    count_d = '0;
    for (int r = 0; r < DEPTH; r++) begin
      count_d = count_d + {{ADDR_W{1'b0}}, pend_d[r]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= '0;
      conflict_q <= 1'b0;
      count_q    <= '0;
    end else begin
      pend_q     <= pend_d;
      conflict_q <= conflict_d;
      count_q    <= count_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_busy
    assign busy_raw_o[k] = pend_q[rd_addr_i[k*ADDR_W +: ADDR_W]];
  end

  assign issue_conflict_o = conflict_q;
  assign busy_count_o     = count_q;

endmodule

// File: rtl/param_regfile.sv
// Parametrised general-purpose register file for the pipelined MIPS core.
// Configurable number of combinational read ports, optional same-cycle
// write-to-read bypass, optional hard-wired zero register, and a pending-write
// scoreboard used by decode for RAW/WAW hazard detection.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   wr_en/addr/data WB write port
//   rd_addr         packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data         packed read data, port k at [k*DATA_W +: DATA_W]
//   rd_busy         port k's register has a write outstanding
//   issue_en/addr   ID issue of an instruction writing issue_addr
//   flush           pipeline redirect, clears all pending bits
//   issue_conflict  registered WAW pulse
//   busy_count      registered count of pending registers
module param_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     flush,
  output logic                     issue_conflict,
  output logic [ADDR_W:0]          busy_count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_ok;
  logic [NUM_RD-1:0] busy_raw;

  // Writes to the hard-wired zero register are dropped.
  assign wr_ok = wr_en && !(ZERO_REG && (wr_addr == ADDR_W'(ZERO_ADDR)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk              (clk),
    .rst_n            (rst_n),
    .issue_en_i       (issue_en),
    .issue_addr_i     (issue_addr),
    .wr_en_i          (wr_en),
    .wr_addr_i        (wr_addr),
    .flush_i          (flush),
    .rd_addr_i        (rd_addr),
    .busy_raw_o       (busy_raw),
    .issue_conflict_o (issue_conflict),
    .busy_count_o     (busy_count)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              is_zero;
    logic              hit;

    assign a       = rd_addr[k*ADDR_W +: ADDR_W];
    assign is_zero = ZERO_REG && (a == ADDR_W'(ZERO_ADDR));
    // A forwarded read already sees the value being written, so it is not busy.
    assign hit     = BYPASS && wr_en && (wr_addr == a);

    assign rd_data[k*DATA_W +: DATA_W] = is_zero ? '0 :
                                         hit     ? wr_data : mem_q[a];
    assign rd_busy[k] = !is_zero && !hit && busy_raw[k];
  end

endmodule

// File: tb/tb_param_regfile.sv
// Testbench for param_regfile: two instances (bypass on and off) share the
// same stimulus; a behavioural model predicts every cycle's outputs, the
// stimulus pushes the prediction into a queue and a monitor pops and checks.
module tb_param_regfile;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           wr_en = 1'b0;
  logic [AW-1:0]  wr_addr = '0;
  logic [DW-1:0]  wr_data = '0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic           issue_en = 1'b0;
  logic [AW-1:0]  issue_addr = '0;
  logic           flush = 1'b0;

  logic [NR*DW-1:0] rd_data_b, rd_data_nb;
  logic [NR-1:0]    rd_busy_b, rd_busy_nb;
  logic             conf_b, conf_nb;
  logic [AW:0]      cnt_b, cnt_nb;

  param_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush),
    .issue_conflict(conf_b), .busy_count(cnt_b));

  param_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1'b0), .ZERO_REG(1'b1)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush),
    .issue_conflict(conf_nb), .busy_count(cnt_nb));

  always #5 clk = ~clk;

  typedef struct {
    int               idx;
    logic [NR*DW-1:0] data_b;
    logic [NR*DW-1:0] data_nb;
    logic [NR-1:0]    busy_b;
    logic [NR-1:0]    busy_nb;
    logic [AW:0]      cnt;
    logic             conf;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   step_idx = 0;

  // Reference model state
  logic [DW-1:0] m_mem [32];
  bit            m_pend [32];
  int            m_cnt;
  bit            m_conf;

  function automatic logic [DW-1:0] exp_data(int a, bit byp);
    if (a == 0) return '0;
    if (byp && wr_en && int'(wr_addr) == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic bit exp_busy(int a, bit byp);
    if (a == 0) return 1'b0;
    if (byp && wr_en && int'(wr_addr) == a) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_cnt = 0;
    m_conf = 1'b0;
  endtask

  task automatic push_exp();
    exp_t e;
    logic [AW-1:0] a;
    e.idx = step_idx;
    for (int k = 0; k < NR; k++) begin
      a = rd_addr[k*AW +: AW];
      e.data_b[k*DW +: DW]  = exp_data(int'(a), 1'b1);
      e.data_nb[k*DW +: DW] = exp_data(int'(a), 1'b0);
      e.busy_b[k]  = exp_busy(int'(a), 1'b1);
      e.busy_nb[k] = exp_busy(int'(a), 1'b0);
    end
    e.cnt  = (AW+1)'(m_cnt);
    e.conf = m_conf;
    q.push_back(e);
    step_idx++;
  endtask

  // Apply the rules of one clock edge to the model.
  task automatic model_edge();
    int ia, wa;
    bit issue_valid;
    ia = int'(issue_addr);
    wa = int'(wr_addr);
    issue_valid = issue_en && !flush && ia != 0;
    m_conf = issue_valid && m_pend[ia] && !(wr_en && wa == ia);
    if (wr_en && wa != 0) m_mem[wa] = wr_data;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    end else begin
      if (wr_en) m_pend[wa] = 1'b0;
      if (issue_valid) m_pend[ia] = 1'b1;
    end
    m_cnt = 0;
    for (int i = 0; i < 32; i++) m_cnt += int'(m_pend[i]);
  endtask

  // Called at posedge+1: predict this cycle, then cross the edge.
  task automatic cyc();
    push_exp();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(int r0, int r1);
    wr_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
    rd_addr = {AW'(r1), AW'(r0)};
  endtask

  // Reset asserted asynchronously a little after an edge, held across one edge.
  task automatic do_reset(int r0, int r1);
    idle(r0, r1);
    rst_n = 1'b0;
    model_clear();
    push_exp();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk(string name, int idx, logic [63:0] act, logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, expv);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rd_data_byp",   e.idx, 64'(rd_data_b),  64'(e.data_b));
        chk("rd_data_nobyp", e.idx, 64'(rd_data_nb), 64'(e.data_nb));
        chk("rd_busy_byp",   e.idx, 64'(rd_busy_b),  64'(e.busy_b));
        chk("rd_busy_nobyp", e.idx, 64'(rd_busy_nb), 64'(e.busy_nb));
        chk("busy_count_b",  e.idx, 64'(cnt_b),      64'(e.cnt));
        chk("busy_count_nb", e.idx, 64'(cnt_nb),     64'(e.cnt));
        chk("conflict_b",    e.idx, 64'(conf_b),     64'(e.conf));
        chk("conflict_nb",   e.idx, 64'(conf_nb),    64'(e.conf));
      end
    end
  end

  initial begin
    int guard;
    model_clear();
    @(posedge clk);
    #1;
    do_reset(5, 0);

    // Write r5, read back on both ports; r0 stays zero.
    idle(0, 0); wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; cyc();
    idle(5, 5); cyc();
    idle(0, 0); wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1; cyc();
    idle(0, 0); cyc();

    // Same-cycle forwarding of r7.
    idle(7, 5); wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55; cyc();
    idle(7, 7); cyc();

    // Issue / write / issue+write on r3.
    idle(3, 3); issue_en = 1'b1; issue_addr = 5'd3; cyc();
    idle(3, 0); cyc();
    idle(3, 3); wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33; cyc();
    idle(3, 0); cyc();
    idle(3, 3); issue_en = 1'b1; issue_addr = 5'd3; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h333; cyc();
    idle(3, 3); cyc();
    idle(3, 0); wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h3333; cyc();

    // WAW on r4.
    idle(4, 0); issue_en = 1'b1; issue_addr = 5'd4; cyc();
    idle(4, 0); issue_en = 1'b1; issue_addr = 5'd4; cyc();
    idle(4, 0); cyc();
    idle(4, 0); cyc();
    idle(4, 0); wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44; cyc();

    // Three pending, then flush with a dropped issue of r10.
    idle(1, 2); issue_en = 1'b1; issue_addr = 5'd1; cyc();
    idle(1, 2); issue_en = 1'b1; issue_addr = 5'd2; cyc();
    idle(9, 2); issue_en = 1'b1; issue_addr = 5'd9; cyc();
    idle(9, 10); issue_en = 1'b1; issue_addr = 5'd10; flush = 1'b1; cyc();
    idle(9, 10); cyc();

    // Issue of r0 is ignored.
    idle(0, 0); issue_en = 1'b1; issue_addr = 5'd0; cyc();
    idle(0, 0); issue_en = 1'b1; issue_addr = 5'd0; cyc();

    // Mid-operation reset.
    idle(6, 6); issue_en = 1'b1; issue_addr = 5'd6; wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h1234; cyc();
    do_reset(6, 6);
    idle(6, 5); cyc();

    // Randomised traffic over a small register window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      wr_en      = ($urandom_range(0, 99) < 50);
      wr_addr    = AW'($urandom_range(0, 7));
      wr_data    = $urandom;
      issue_en   = ($urandom_range(0, 99) < 45);
      issue_addr = AW'($urandom_range(0, 7));
      flush      = ($urandom_range(0, 99) < 5);
      rd_addr    = {AW'($urandom_range(0, 8)), AW'($urandom_range(0, 8))};
      if ($urandom_range(0, 99) < 15) rd_addr[2*AW-1:AW] = wr_addr;
      if ($urandom_range(0, 199) == 0) do_reset(int'(wr_addr), 0);
      else cyc();
    end
    idle(0, 0);

    // Let the monitor drain, bounded.
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/param_regfile.md
# param_regfile

Parametrised general-purpose register file for the pipelined MIPS core, replacing the fixed 32×32 two-read-port file. It adds a configurable number of read ports, optional write-to-read bypass, and a per-register pending-write scoreboard. The decode stage uses the scoreboard to detect RAW hazards on long-latency results, such as cache-miss loads. It sits between ID (reads, issue) and WB (writes).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth is 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data is forwarded to reads
- ZERO_REG, 1, 1 = register 0 is hard-wired to zero and is never pending

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; asynchronous, active-low
- wr_en  in  1  WB write strobe
- wr_addr  in  ADDR_W  WB destination register
- wr_data  in  DATA_W  WB result
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, packed the same way as rd_addr
- rd_busy  out  NUM_RD  port k's register has a write outstanding
- issue_en  in  1  ID issues an instruction that will write issue_addr
- issue_addr  in  ADDR_W  destination of the issuing instruction
- flush  in  1  pipeline redirect; clears all pending bits
- issue_conflict  out  1  registered pulse: the last issue targeted an already-pending register
- busy_count  out  ADDR_W+1  registered count of pending registers

## Operation
- Storage is an array of 2**ADDR_W words.
- On a clock edge with wr_en=1, mem[wr_addr] <= wr_data. When ZERO_REG=1, writes to address 0 are discarded.
- Reads are combinational. With ZERO_REG=1, address 0 returns 0.
- With BYPASS=1, a read of wr_addr while wr_en=1 returns wr_data (bypass does not apply to address 0 when ZERO_REG=1). With BYPASS=0, the read returns the old contents.
- The scoreboard holds one pending bit per register.
- Next-state priority for bit r, highest first:
  - flush: bit cleared.
  - Issue to r: bit set, whether or not a write to r also occurs.
  - wr_en with wr_addr == r: bit cleared.
  - Otherwise: bit held.
- Issue to an already-pending register (with no clearing write to it in the same cycle, and no flush) is a WAW violation:
  - The bit stays set.
  - issue_conflict is 1 for the next cycle.
- Issue while flush=1 is dropped and does not assert issue_conflict.
- Issue to register 0 with ZERO_REG=1 is ignored and does not assert issue_conflict.
- rd_busy[k] = pending[rd_addr_k].
  - With BYPASS=1, rd_busy[k] is masked to 0 when wr_en=1 and wr_addr matches, because the data is being forwarded.
  - With ZERO_REG=1, rd_busy[k] is 0 for address 0.
- busy_count equals the popcount of the pending bits as they stand after the most recent edge.

## Timing
- Reset (asserted asynchronously):
  - All words are 0.
  - All pending bits are 0.
  - busy_count = 0 and issue_conflict = 0.
  - rd_data reflects zeros immediately.
- A write is visible to reads in the cycle after the edge. With BYPASS=1 it is also visible combinationally in the same cycle.
- An issue makes rd_busy visible the cycle after issue_en is sampled.
- busy_count and issue_conflict lag the causing edge by zero cycles: both are registered at the same edge as the pending-bit update.
- Reset asserted mid-operation clears everything with no completion of in-flight writes. Operation resumes on the first edge after rst_n deasserts.
- Ports behave independently: all NUM_RD ports may address the same register, and each receives identical data and busy.

## Structure
- Package regfile_pkg holds the default DATA_W, ADDR_W and NUM_RD values and the ZERO_ADDR constant.
- Sub-module regfile_scoreboard holds the pending bits, the priority logic, issue_conflict and busy_count. It takes the issue, write and flush inputs and the read addresses, and outputs rd_busy before bypass masking.
- param_regfile contains the storage array, the read muxes and the bypass/mask logic.

## Test plan
- Reset, then write 0xDEADBEEF to r5. Next cycle, read r5 on both ports -> 0xDEADBEEF on both; r0 reads 0 even after a write of 0x1 to r0.
- BYPASS=1: in the same cycle, wr_en, wr_addr=7, wr_data=0x55 and rd_addr0=7 -> rd_data0=0x55 that cycle. With BYPASS=0 -> old value 0.
- Issue r3 -> next cycle rd_busy=1 for r3 and busy_count=1. Write r3 -> next cycle rd_busy=0 and busy_count=0. Issue r3 and write r3 in the same cycle -> r3 stays busy.
- Issue r4 twice in consecutive cycles without a write -> issue_conflict=1 for exactly one cycle and busy_count=1.
- Issue r1, r2 and r9 -> busy_count=3. Assert flush together with issue r10 -> next cycle busy_count=0, nothing busy, issue_conflict=0.
- Issue r6 and write r6=0x1234, then assert rst_n low asynchronously mid-cycle -> all rd_data=0, busy_count=0 and rd_busy=0 immediately.
